unshift_engine: RTL and testbench

UNSHIFT_ENGINE -- requirements
Module: unshift_engine

---
 rtl/unshift_engine_pkg.sv | 17 +
 rtl/unshift_step.sv | 17 +
 rtl/unshift_engine.sv | 114 +++++++++++
 tb/tb_unshift_engine.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/unshift_engine_pkg.sv
// Shared coefficient codes for the forward shifter and its inverse, plus the
// one-bit step direction used by the unshift datapath.
package unshift_engine_pkg;

  typedef enum logic [1:0] {
    COEF_LEFT2 = 2'b00,
    COEF_LEFT4 = 2'b01,
    COEF_RIGHT = 2'b10,
    COEF_BAD   = 2'b11
  } coef_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/unshift_step.sv
// One-bit logical shift in the selected direction, zero-filling the vacated bit.
module unshift_step
  import unshift_engine_pkg::*;
#(
  parameter int size = 5
) (
  input  logic [size-1:0] din,
  input  dir_e            dir,
  output logic [size-1:0] dout
);

  always_comb begin
    if (dir == DIR_LEFT) dout = {din[size-2:0], 1'b0};
    else                 dout = {1'b0, din[size-1:1]};
  end

endmodule

// File: rtl/unshift_engine.sv
// Serial inverse of the forward shifter: one bit position per clock, with an
// err flag for words the forward shifter could not have produced.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; in_ready and out_valid are pure decodes of the state register, so
// neither depends combinationally on in_valid or out_ready.
module unshift_engine
  import unshift_engine_pkg::*;
#(
  parameter int size = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] shifted,
  input  logic [1:0]      coefficient,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] data,
  output logic            err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [size-1:0] work_q, work_d;
  logic            err_q, err_d;
  dir_e            dir_q, dir_d;
  logic [size-1:0] step_out;

  unshift_step #(.size(size)) u_step (
    .din  (work_q),
    .dir  (dir_q),
    .dout (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      err_q   <= 1'b0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    err_d   = err_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = shifted;
          state_d = ST_SHIFT;
          case (coefficient)
            COEF_LEFT2: begin
              dir_d = DIR_RIGHT;
              cnt_d = 2'd1;
              err_d = shifted[0];
            end
            COEF_LEFT4: begin
              dir_d = DIR_RIGHT;
              cnt_d = 2'd2;
              err_d = |shifted[1:0];
            end
            COEF_RIGHT: begin
              dir_d = DIR_LEFT;
              cnt_d = 2'd1;
              err_d = shifted[size-1];
            end
            default: begin
              // Invalid code: pass the word through untouched and flag it.
              cnt_d   = 2'd0;
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign data      = work_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_unshift_engine.sv
// Scoreboard bench for unshift_engine: directed corner words, random words,
// backpressure and mid-word reset.
module tb_unshift_engine;

  localparam int SIZE = 5;
  localparam int W    = SIZE + 1;
  localparam int MAX_WAIT = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] shifted;
  logic [1:0]      coefficient;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] data;
  logic            err;
  logic [1:0]      dbg_state;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_vec;
  int           n_err;

  unshift_engine #(.size(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .shifted     (shifted),
    .coefficient (coefficient),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data        (data),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the inverse shifter; lat is edges after the accept edge.
  task automatic model(input logic [1:0] coef, input logic [SIZE-1:0] sh,
                       output logic [SIZE-1:0] d, output logic e, output int lat);
    case (coef)
      2'b00: begin d = sh >> 1; e = sh[0];        lat = 1; end
      2'b01: begin d = sh >> 2; e = (sh[1:0] != 2'b00); lat = 2; end
      2'b10: begin d = sh << 1; e = sh[SIZE-1];   lat = 1; end
      default: begin d = sh;    e = 1'b1;         lat = 0; end
    endcase
  endtask

  // Drive one word, wait for the result, optionally stall the consumer.
  task automatic run_word(input logic [1:0] coef, input logic [SIZE-1:0] sh, input int hold);
    logic [SIZE-1:0] md;
    logic            me;
    int              ml;
    logic [W-1:0]    exp;
    int              lat;
    check("idle_in_ready", in_ready, 1);
    model(coef, sh, md, me, ml);
    exp_q.push_back({me, md});
    lat_q.push_back(ml);
    in_valid    = 1'b1;
    coefficient = coef;
    shifted     = sh;
    out_ready   = (hold == 0);
    tick();
    in_valid    = 1'b0;
    shifted     = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    coefficient = 2'($urandom_range(0, 3));
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    exp = exp_q.pop_front();
    check("latency", lat, lat_q.pop_front());
    check("data", data, exp[SIZE-1:0]);
    check("err", err, exp[SIZE]);
    for (int i = 0; i < hold; i++) begin
      in_valid    = 1'b1;
      shifted     = SIZE'($urandom_range(0, (1 << SIZE) - 1));
      coefficient = 2'($urandom_range(0, 3));
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_result", {err, data}, exp);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("pre_pop_valid", out_valid, 1);
    tick();
    check("post_pop_valid", out_valid, 0);
    check("post_pop_ready", in_ready, 1);
    check("idle_keeps_result", {err, data}, exp);
    out_ready = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    shifted     = '0;
    coefficient = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);

    // directed corner words
    run_word(2'b00, 5'b10110, 0);
    run_word(2'b01, 5'b01100, 0);
    run_word(2'b10, 5'b01011, 0);
    run_word(2'b10, 5'b10011, 0);
    run_word(2'b01, 5'b01101, 0);
    run_word(2'b11, 5'b10101, 0);
    // backpressure: three stalled cycles, consumed on the fourth
    run_word(2'b00, 5'b11010, 3);

    // reset during the first SHIFT cycle of a LEFT4 word
    in_valid    = 1'b1;
    coefficient = 2'b01;
    shifted     = 5'b01100;
    out_ready   = 1'b1;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", dbg_state, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_data", data, 0);
    check("abort_err", err, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_result", out_valid, 0);
      tick();
    end
    out_ready = 1'b0;

    // random words with random stalls
    for (int i = 0; i < 24; i++) begin
      run_word(2'($urandom_range(0, 3)), SIZE'($urandom_range(0, (1 << SIZE) - 1)),
               $urandom_range(0, 2));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
